uart_prog_loader: RTL
=====================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 16, number of 32-bit instruction words loaded first.
REQ-002 SHALL have parameter DMEM_WORDS, default 8, number of 32-bit data words loaded after the instruction words.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 8680, the maximum idle clocks allowed between bytes of one word.
REQ-004 Port sys_clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port sys_arst, input, 1, reset, asynchronous and active-high.
REQ-006 Port rx_valid, input, 1, one-cycle strobe marking a received UART byte.
REQ-007 Port rx_data, input, 8, received byte, qualified by rx_valid.
REQ-008 Port rx_ferr, input, 1, one-cycle framing-error strobe from the UART receiver.
REQ-009 Port imem_we, output, 1, instruction-memory write strobe.
REQ-010 Port imem_addr, output, clog2(IMEM_WORDS), instruction word index.
REQ-011 Port dmem_we, output, 1, data-memory write strobe.
REQ-012 Port dmem_addr, output, clog2(DMEM_WORDS), data word index.
REQ-013 Port mem_wdata, output, 32, write data shared by both memories.
REQ-014 Port cpu_rst, output, 1, active-high hold-reset for the CPU core.
REQ-015 Port load_done, output, 1, high once loading has completed.
REQ-016 Port load_err, output, 1, high once loading has aborted.

Function
REQ-017 SHALL assemble bytes MSB-first: the 1st byte of a word goes to bits [31:24] and the 4th byte to [7:0].
REQ-018 SHALL implement states LOAD_IMEM, LOAD_DMEM, DONE and ERROR, entering LOAD_IMEM on reset.
REQ-019 SHALL pulse exactly one write strobe for one cycle, with address and mem_wdata valid, in the cycle after the 4th byte's rx_valid.
REQ-020 SHALL write words 0..IMEM_WORDS-1 to imem, then words 0..DMEM_WORDS-1 to dmem, with the address incrementing by 1 per word.
REQ-021 SHALL move LOAD_IMEM->LOAD_DMEM on the write of imem word IMEM_WORDS-1.
REQ-022 SHALL move LOAD_DMEM->DONE on the write of dmem word DMEM_WORDS-1.
REQ-023 SHALL keep cpu_rst high in all states except DONE and deassert it in the same cycle load_done rises.
REQ-024 SHALL ignore rx_valid and rx_ferr in DONE and ERROR, which are terminal until reset.
REQ-025 SHALL go to ERROR on rx_ferr in LOAD_IMEM or LOAD_DMEM, discarding any partial word and issuing no write.
REQ-026 SHALL count idle clocks while 1-3 bytes of a word are held.
REQ-027 On reaching TIMEOUT_CYC, SHALL discard the partial word, clear the byte count and stay in the current state with the address unchanged.
REQ-028 If rx_valid and rx_ferr assert in the same cycle, SHALL treat it as rx_ferr, so the byte is dropped.
REQ-029 SHALL restart the timeout counter on every accepted byte.
REQ-030 SHALL hold the timeout counter at zero when the byte count is 0.
REQ-031 SHALL hold imem_we=0 and dmem_we=0 outside their respective write cycles; mem_wdata may hold its last value.

Reset
REQ-032 On sys_arst SHALL immediately set the state to LOAD_IMEM and clear the byte count, word addresses, timeout counter and mem_wdata.
REQ-033 On sys_arst SHALL immediately set imem_we=0, dmem_we=0, cpu_rst=1, load_done=0 and load_err=0.
REQ-034 Reset mid-word or mid-load SHALL abort without any further write strobe; loading restarts from imem word 0.

Structure
REQ-035 SHALL place the state encoding and the default of the bytes-per-word constant (4) in a shared package loader_pkg.
REQ-036 SHALL contain one sub-module, byte_packer, holding the shift register, 2-bit byte count, timeout counter and word_valid pulse output.
REQ-037 The top level SHALL hold only the FSM, address counters and output registers.

Verification
REQ-038 Bytes 00 00 20 83 -> one-cycle imem_we, imem_addr=0, mem_wdata=0x00002083, cpu_rst still 1.
REQ-039 Full 96-byte stream (4 instructions, then 48 zero bytes, then 00 00 00 0A 00 00 00 45, then 24 zero bytes):
- 16 imem writes (addresses 0-15) and 8 dmem writes (addresses 0-7);
- dmem word0=0x0000000A, word1=0x00000045;
- load_done=1 and cpu_rst=0 in the cycle after the final dmem write.
REQ-040 Bytes 00 00 20, then TIMEOUT_CYC idle clocks, then 00 40 21 03 -> single imem write of 0x00402103 at address 0.
REQ-041 rx_ferr after 2 bytes of imem word 5 -> load_err=1, no further writes, cpu_rst stays 1, and later bytes are ignored.
REQ-042 sys_arst pulse after 3 bytes of dmem word 2 -> no write issued; the subsequent stream writes imem address 0 first.
REQ-043 Extra bytes after DONE -> no write strobes, and load_done and cpu_rst are unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    LOAD_IMEM = 2'd0,
    LOAD_DMEM = 2'd1,
    DONE      = 2'd2,
    ERROR     = 2'd3
  } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs received UART bytes MSB-first into 32-bit words. A partial word is
// dropped on a framing error or when the gap between bytes grows too long.
module byte_packer
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8680,
  parameter int BPW         = BYTES_PER_WORD
) (
  input  logic        sys_clk,
  input  logic        sys_arst,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_ferr,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [31:0]   shift_q, shift_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          accept;

  // A byte coinciding with a framing error is never accepted.
  assign accept = en & rx_valid & ~rx_ferr;

  // Shift/count/timeout update; word_valid fires combinationally on the last byte.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    word_valid = 1'b0;
    word       = {shift_q[23:0], rx_data};
    if (rx_ferr) begin
      cnt_d = 2'd0;
      tmo_d = '0;
    end else if (accept) begin
      shift_d = word;
      tmo_d   = '0;
      if (cnt_q == 2'(BPW - 1)) begin
        cnt_d      = 2'd0;
        word_valid = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (cnt_q != 2'd0) begin
      // Idle clock with a partial word held.
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        cnt_d = 2'd0;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
      tmo_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads instruction then data memory from a UART byte stream while holding
// the CPU in reset; releases the CPU once both memories are filled.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS  = 16,
  parameter int DMEM_WORDS  = 8,
  parameter int TIMEOUT_CYC = 8680,
  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1,
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1
) (
  input  logic           sys_clk,
  input  logic           sys_arst,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  input  logic           rx_ferr,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [31:0]    mem_wdata,
  output logic           cpu_rst,
  output logic           load_done,
  output logic           load_err
);

  load_state_e    state_q, state_d;
  logic [IAW-1:0] imem_idx_q, imem_idx_d, imem_addr_q, imem_addr_d;
  logic [DAW-1:0] dmem_idx_q, dmem_idx_d, dmem_addr_q, dmem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic           cpu_rst_q, cpu_rst_d, load_done_q, load_done_d, load_err_q, load_err_d;
  logic           loading, word_valid;
  logic [31:0]    word;

  assign loading = (state_q == LOAD_IMEM) || (state_q == LOAD_DMEM);

  byte_packer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_packer (
    .sys_clk    (sys_clk),
    .sys_arst   (sys_arst),
    .en         (loading),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) state_q <= LOAD_IMEM;
    else          state_q <= state_d;
  end

  // Next state: advance on the last word of each memory, abort on framing error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_IMEM: begin
        if (rx_ferr) state_d = ERROR;
        else if (word_valid && imem_idx_q == IAW'(IMEM_WORDS - 1)) state_d = LOAD_DMEM;
      end
      LOAD_DMEM: begin
        if (rx_ferr) state_d = ERROR;
        else if (word_valid && dmem_idx_q == DAW'(DMEM_WORDS - 1)) state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs and address counters; status flags follow the registered state.
  always_comb begin
    imem_we_d   = word_valid && (state_q == LOAD_IMEM);
    dmem_we_d   = word_valid && (state_q == LOAD_DMEM);
    imem_idx_d  = imem_we_d ? imem_idx_q + IAW'(1) : imem_idx_q;
    dmem_idx_d  = dmem_we_d ? dmem_idx_q + DAW'(1) : dmem_idx_q;
    imem_addr_d = imem_we_d ? imem_idx_q : imem_addr_q;
    dmem_addr_d = dmem_we_d ? dmem_idx_q : dmem_addr_q;
    mem_wdata_d = (imem_we_d || dmem_we_d) ? word : mem_wdata_q;
    cpu_rst_d   = (state_q != DONE);
    load_done_d = (state_q == DONE);
    load_err_d  = (state_q == ERROR);
  end

  // Output and counter registers.
  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      imem_idx_q  <= '0;
      dmem_idx_q  <= '0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      mem_wdata_q <= '0;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      imem_idx_q  <= imem_idx_d;
      dmem_idx_q  <= dmem_idx_d;
      imem_addr_q <= imem_addr_d;
      dmem_addr_q <= dmem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign imem_addr = imem_addr_q;
  assign dmem_addr = dmem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
